// File: rtl/sm_delta_decoder.sv
`default_nettype none
// ============================================================================
// Module      : sm_delta_decoder
// Description : Streaming sign-magnitude delta decoder. Every accepted delta is
//               integrated into a running two's-complement accumulator, and the
//               reconstructed sample is emitted in sign-magnitude form through a
//               single valid/ready output register. The first sample of a frame
//               is absolute.
// Ports       : clk, rst (async, active-high)  clock / reset
//               clr                           sync clear: back to IDLE, output dropped
//               in_vld/in_rdy/in_first/in_data     input delta stream
//               out_vld/out_rdy/out_data/out_first/out_ovf  reconstructed stream
//               frame_cnt                     samples emitted in current frame
// Config      : SM_DELTA_SAT_EN defined   -> out-of-range sums saturate,
//                                            out_ovf marks that one sample
//               SM_DELTA_SAT_EN undefined -> out-of-range sums wrap the magnitude,
//                                            out_ovf is sticky until frame restart
// Revision    : 1.0  initial release
// ============================================================================
module sm_delta_decoder #(
    parameter int DW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic             in_first,
    input  logic [DW-1:0]    in_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [DW-1:0]    out_data,
    output logic             out_first,
    output logic             out_ovf,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int MAG_W = DW - 1;
    localparam int AW    = DW + 1;   // accumulator / sum width, never loses bits

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [AW-1:0]    r_acc;

    logic             w_xfer;
    logic             w_first;
    logic [AW-1:0]    w_mag_ext;
    logic [AW-1:0]    w_delta;
    logic [AW-1:0]    w_base;
    logic [AW-1:0]    w_sum;
    logic             w_neg;
    logic [AW-1:0]    w_abs;
    logic             w_event;
    logic [MAG_W-1:0] w_mag;
    logic             w_sign;
    logic             w_ovf;
    logic [AW-1:0]    w_acc_next;
    logic [CNT_W-1:0] w_cnt_next;

    // Single output register: new data may enter whenever the slot is empty
    // or is being drained on this same edge.
    assign in_rdy = ~out_vld | out_rdy;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = IDLE;
        end else if (w_xfer) begin
            w_state_next = RUN;
        end
    end

    // ------------------------------------------------------- datapath
    always_comb begin
        w_xfer    = in_vld & in_rdy & ~clr;
        // A transfer outside a frame always starts one.
        w_first   = in_first | (r_state == IDLE);
        w_mag_ext = {2'b00, in_data[MAG_W-1:0]};
        // -0 naturally maps to 0 here because the negation of zero is zero.
        w_delta   = in_data[DW-1] ? (~w_mag_ext + {{(AW-1){1'b0}}, 1'b1}) : w_mag_ext;
        w_base    = w_first ? '0 : r_acc;
        w_sum     = w_base + w_delta;
        w_neg     = w_sum[AW-1];
        w_abs     = w_neg ? (~w_sum + {{(AW-1){1'b0}}, 1'b1}) : w_sum;
        // |sum| exceeds the largest representable magnitude.
        w_event   = |w_abs[AW-1:MAG_W];
`ifdef SM_DELTA_SAT_EN
        w_mag     = w_event ? {MAG_W{1'b1}} : w_abs[MAG_W-1:0];
        w_ovf     = w_event;
`else
        w_mag     = w_abs[MAG_W-1:0];
        // out_ovf doubles as the sticky flag; it is only ever cleared by a
        // frame restart, clr or rst.
        w_ovf     = w_event | (out_ovf & ~w_first);
`endif
        // Never emit negative zero.
        w_sign     = w_neg & (|w_mag);
        w_acc_next = w_sign ? (~{2'b00, w_mag} + {{(AW-1){1'b0}}, 1'b1})
                            : {2'b00, w_mag};
        w_cnt_next = w_first ? {{(CNT_W-1){1'b0}}, 1'b1}
                             : frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            out_vld   <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_ovf   <= 1'b0;
            frame_cnt <= '0;
        end else if (clr) begin
            r_acc     <= '0;
            out_vld   <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_ovf   <= 1'b0;
            frame_cnt <= '0;
        end else if (w_xfer) begin
            r_acc     <= w_acc_next;
            out_vld   <= 1'b1;
            out_data  <= {w_sign, w_mag};
            out_first <= w_first;
            out_ovf   <= w_ovf;
            frame_cnt <= w_cnt_next;
        end else if (out_rdy) begin
            out_vld   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sm_delta_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_delta_decoder
// Description : Scoreboard bench for sm_delta_decoder (DW=16). The driver keeps
//               an integer reference model of the frame arithmetic and queues
//               the expected sample per accepted transfer; a monitor pops and
//               compares on each output handshake.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sm_delta_decoder;

    localparam int DW    = 16;
    localparam int CNT_W = 16;
    localparam int MAXM  = 32767;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             in_vld;
    logic             in_rdy;
    logic             in_first;
    logic [DW-1:0]    in_data;
    logic             out_vld;
    logic             out_rdy;
    logic [DW-1:0]    out_data;
    logic             out_first;
    logic             out_ovf;
    logic [CNT_W-1:0] frame_cnt;

    sm_delta_decoder #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_first  (in_first),
        .in_data   (in_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .out_first (out_first),
        .out_ovf   (out_ovf),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        first;
        logic        ovf;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state
    bit   m_active = 0;
    int   m_acc    = 0;
    bit   m_sticky = 0;
    int   m_cnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_active = 0;
        m_acc    = 0;
        m_sticky = 0;
        m_cnt    = 0;
        sb.delete();
    endfunction

    function automatic void model_xfer(input bit f, input logic [15:0] d);
        int   mag;
        int   delta;
        int   sum;
        int   amag;
        int   res;
        int   rmag;
        bit   ev;
        bit   fo;
        exp_t e;
        mag   = int'(d[14:0]);
        delta = d[15] ? -mag : mag;
        fo    = f || !m_active;
        sum   = (fo ? 0 : m_acc) + delta;
        amag  = (sum < 0) ? -sum : sum;
        ev    = amag > MAXM;
`ifdef SM_DELTA_SAT_EN
        res   = ev ? ((sum < 0) ? -MAXM : MAXM) : sum;
        e.ovf = ev;
`else
        rmag  = amag % (MAXM + 1);
        res   = (sum < 0) ? -rmag : rmag;
        if (fo) m_sticky = 0;
        m_sticky = m_sticky | ev;
        e.ovf = m_sticky;
`endif
        rmag    = (res < 0) ? -res : res;
        e.data  = {(res < 0) ? 1'b1 : 1'b0, rmag[14:0]};
        e.first = fo;
        m_cnt   = fo ? 1 : ((m_cnt + 1) & 16'hFFFF);
        e.cnt   = m_cnt[15:0];
        m_acc    = res;
        m_active = 1;
        sb.push_back(e);
    endfunction

    // One clock of stimulus, entered and left at posedge+1.
    task automatic step(input bit v, input bit f, input logic [15:0] d,
                        input bit ordy, input bit c);
        bit exp_rdy;
        in_vld   = v;
        in_first = f;
        in_data  = d;
        out_rdy  = c ? 1'b0 : ordy;  // never handshake in the clr cycle
        clr      = c;
        @(negedge clk);
        exp_rdy = (sb.size() == 0) || out_rdy;
        chk("in_rdy", {31'd0, in_rdy}, {31'd0, exp_rdy});
        if (c) model_reset();
        else if (v && exp_rdy) model_xfer(f, d);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic check_reset_state();
        chk("rst_out_vld",   {31'd0, out_vld},   32'd0);
        chk("rst_out_data",  {16'd0, out_data},  32'd0);
        chk("rst_out_first", {31'd0, out_first}, 32'd0);
        chk("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_in_rdy",    {31'd0, in_rdy},    32'd1);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        rst    = 1'b1;
        in_vld = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_state();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare on every output handshake.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got data %0h with no expected sample", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_data !== e.data || out_first !== e.first ||
                    out_ovf !== e.ovf || frame_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL out_sample: got data=%0h first=%0b ovf=%0b cnt=%0d expected data=%0h first=%0b ovf=%0b cnt=%0d",
                             out_data, out_first, out_ovf, frame_cnt,
                             e.data, e.first, e.ovf, e.cnt);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        clr      = 1'b0;
        in_vld   = 1'b0;
        in_first = 1'b0;
        in_data  = '0;
        out_rdy  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // frame: -5, +7, -2 -> -5, 2, 0
        step(1, 1, 16'h8005, 1, 0);
        step(1, 0, 16'h0007, 1, 0);
        step(1, 0, 16'h8002, 1, 0);
        // negative zero as frame start
        step(1, 1, 16'h8000, 1, 0);
        // positive overflow
        step(1, 1, 16'h7FFF, 1, 0);
        step(1, 0, 16'h0001, 1, 0);
        step(1, 0, 16'h8001, 1, 0);
        step(1, 0, 16'h0002, 1, 0);
        // frame restart mid-frame
        step(1, 1, 16'h0064, 1, 0);
        // backpressure with input pending, then full throughput
        step(1, 0, 16'h0003, 0, 0);
        step(1, 0, 16'h0004, 0, 0);
        step(1, 0, 16'h0005, 0, 0);
        step(1, 0, 16'h0006, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 16'(i + 1), 1, 0);
        // async reset mid-frame, then a plain delta starts a new frame
        step(1, 0, 16'h0009, 0, 0);
        async_reset();
        step(1, 0, 16'h0003, 1, 0);
        // clr with concurrent transfer
        step(1, 0, 16'h0011, 0, 0);
        step(1, 0, 16'h0022, 1, 1);
        chk("clr_out_vld", {31'd0, out_vld}, 32'd0);
        step(1, 0, 16'h8004, 1, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(3) == 0) d[14:12] = 3'b111;  // provoke range events
            if ($urandom_range(79) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(3) != 0, $urandom_range(9) == 0, d,
                     $urandom_range(3) != 0, $urandom_range(49) == 0);
            end
        end

        // drain
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            step(0, 0, 16'h0000, 1, 0);
        end
        chk("drain_left", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
